cas_key_loader: RTL

- Sequences delivery of the 64-bit CAS-Lock key from on-chip secure NVM into the `keyinput_*` bus of a locked combinational netlist (c432-class).
- Fetches the key as 8-bit words over a req/ack port and verifies an XOR checksum word.
- Only a verified key is presented; `key_valid` is asserted on success.
- Repeated failures drive a sticky lockout, denying brute-force reload attempts.

---
 rtl/cas_key_pkg.sv | 19 +
 rtl/cas_key_stage.sv | 51 +++++
 rtl/cas_key_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cas_key_pkg.sv
// Shared types and sizing for the CAS-Lock key loader.
package cas_key_pkg;

  localparam int unsigned KEY_W_DEF  = 64;
  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned NUM_WORDS  = KEY_W_DEF / WORD_W_DEF;
  localparam int unsigned CSUM_ADDR  = NUM_WORDS;
  localparam int unsigned ADDR_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CHECK,
    S_ARMED,
    S_LOCKOUT
  } state_e;

endpackage

// File: rtl/cas_key_stage.sv
// Staging register and running XOR accumulator for the key words being fetched.
module cas_key_stage
  import cas_key_pkg::*;
#(
  parameter int unsigned KEY_W  = KEY_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned AW     = ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [KEY_W-1:0]  key_o,
  output logic [WORD_W-1:0] acc_o
);

  localparam int unsigned NW = KEY_W / WORD_W;

  logic [KEY_W-1:0]  key_q, key_d;
  logic [WORD_W-1:0] acc_q, acc_d;

  always_comb begin
    key_d = key_q;
    acc_d = acc_q;
    if (clr_i) begin
      key_d = '0;
      acc_d = '0;
    end else if (we_i) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (addr_i == AW'(w)) key_d[w*WORD_W +: WORD_W] = data_i;
      end
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      acc_q <= '0;
    end else begin
      key_q <= key_d;
      acc_q <= acc_d;
    end
  end

  assign key_o = key_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/cas_key_loader.sv
// Fetches the CAS-Lock key from NVM, verifies its XOR checksum and presents it
// on the keyinput bus; repeated failures latch a lockout until reset.
module cas_key_loader
  import cas_key_pkg::*;
#(
  parameter int unsigned KEY_W     = KEY_W_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  output logic              nvm_req,
  output logic [3:0]        nvm_addr,
  input  logic              nvm_ack,
  input  logic [WORD_W-1:0] nvm_data,
  output logic [KEY_W-1:0]  keyinput,
  output logic              key_valid,
  output logic              busy,
  output logic [3:0]        fail_cnt,
  output logic              lockout
);

  localparam int unsigned N_WORDS = KEY_W / WORD_W;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          tmo_q;
  logic                tmo_flag_q;
  logic [WORD_W-1:0]   csum_q;
  logic                req_q;
  logic                busy_q;
  logic                valid_q;
  logic [KEY_W-1:0]    key_q;
  logic [3:0]          fail_q;
  logic                lock_q;

  logic                stg_clr, stg_we, csum_ok, retry_ok, start_ok, at_csum;
  logic [KEY_W-1:0]    stg_key;
  logic [WORD_W-1:0]   stg_acc;

  assign start_ok = (state_q == S_IDLE || state_q == S_ARMED) && load_start;
  assign at_csum  = (addr_q == ADDR_W'(N_WORDS));
  assign csum_ok  = !tmo_flag_q && (stg_acc == csum_q);
  assign retry_ok = (32'(fail_q) + 32'd1) < MAX_RETRY;
  assign stg_we   = (state_q == S_WAIT) && nvm_ack && !at_csum;
  // A failed CHECK that still has retries left restarts from a clean stage.
  assign stg_clr  = start_ok || ((state_q == S_CHECK) && !csum_ok && retry_ok);

  cas_key_stage #(
    .KEY_W (KEY_W),
    .WORD_W(WORD_W),
    .AW    (ADDR_W)
  ) u_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stg_clr),
    .we_i  (stg_we),
    .addr_i(addr_q),
    .data_i(nvm_data),
    .key_o (stg_key),
    .acc_o (stg_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
      csum_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      key_q      <= '0;
      fail_q     <= '0;
      lock_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ARMED: begin
          if (load_start) begin
            state_q    <= S_REQ;
            addr_q     <= '0;
            tmo_flag_q <= 1'b0;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
            key_q      <= '0;
          end
        end
        S_REQ: begin
          req_q   <= 1'b1;
          tmo_q   <= 8'(TIMEOUT);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (nvm_ack) begin
            req_q <= 1'b0;
            if (at_csum) begin
              csum_q  <= nvm_data;
              state_q <= S_CHECK;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= S_REQ;
            end
          end else if (tmo_q <= 8'd1) begin
            req_q      <= 1'b0;
            tmo_q      <= '0;
            tmo_flag_q <= 1'b1;
            state_q    <= S_CHECK;
          end else begin
            tmo_q <= tmo_q - 8'd1;
          end
        end
        S_CHECK: begin
          if (csum_ok) begin
            key_q   <= stg_key;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ARMED;
          end else begin
            if (fail_q != 4'hF) fail_q <= fail_q + 4'd1;
            if (retry_ok) begin
              addr_q     <= '0;
              tmo_flag_q <= 1'b0;
              state_q    <= S_REQ;
            end else begin
              lock_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_LOCKOUT;
            end
          end
        end
        S_LOCKOUT: begin
          state_q <= S_LOCKOUT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nvm_req   = req_q;
  assign nvm_addr  = addr_q;
  assign keyinput  = key_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign fail_cnt  = fail_q;
  assign lockout   = lock_q;

endmodule
